lpc_frame_scheduler: RTL and testbench

- Sequences the shared synchronous FIFO (FIFO_DEPTH x DATA_WIDTH, registered read data, 1-cycle read latency) between the AXI-Stream sample input and the LPC analysis core.
- Owns both FIFO ports and tracks FIFO occupancy internally.
- Releases samples downstream only as complete, bubble-free frames of FRAME_LEN words, with TLAST on the final word of each frame.

---
 rtl/lpc_enc_pkg.sv | 6 +
 rtl/lpc_out_skid.sv | 40 ++++
 rtl/lpc_frame_scheduler.sv | 85 ++++++++
 tb/tb_lpc_frame_scheduler.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/lpc_enc_pkg.sv
// lpc_enc_pkg: shared state encoding and defaults for the LPC frame scheduler
package lpc_enc_pkg;
  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int FRAME_LEN_DEF = 64;
endpackage

// File: rtl/lpc_out_skid.sv
// lpc_out_skid: 2-entry output buffer holding data plus a last flag per word
module lpc_out_skid #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  input  logic         pop,
  output logic [W-1:0] data,
  output logic         last,
  output logic [1:0]   cnt
);
  logic [W-1:0] tail_data;
  logic         tail_last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data      <= '0;
      last      <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
      cnt       <= 2'd0;
    end else begin
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      // head only moves on pop or when filling an empty buffer, so it is stable while waiting
      if (pop) begin
        data <= (cnt == 2'd2) ? tail_data : push_data;
        last <= (cnt == 2'd2) ? tail_last : push_last;
      end else if (push && cnt == 2'd0) begin
        data <= push_data;
        last <= push_last;
      end
      if (push && (pop || cnt != 2'd0)) begin
        tail_data <= push_data;
        tail_last <= push_last;
      end
    end
  end
endmodule

// File: rtl/lpc_frame_scheduler.sv
// lpc_frame_scheduler: gathers FIFO samples and releases them as whole, gap-free frames
module lpc_frame_scheduler
  import lpc_enc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = 128,
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int CNT_W      = 16,
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  ACLK,
  input  logic                  ARESET_N,
  input  logic                  ENABLE,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  output logic                  FIFO_WR_EN,
  output logic [DATA_WIDTH-1:0] FIFO_WR_DATA,
  output logic                  FIFO_RD_EN,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  input  logic                  FIFO_EMPTY,
  input  logic                  FIFO_FULL,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  output logic [LW-1:0]         FILL_LEVEL,
  output logic                  FRAME_DONE,
  output logic [CNT_W-1:0]      FRAME_CNT
);
  if (FRAME_LEN < 1 || FRAME_LEN > FIFO_DEPTH) begin : g_bad_frame_len
    $error("FRAME_LEN must lie in 1..FIFO_DEPTH");
  end
  state_t        state;
  logic [LW-1:0] level, reads;
  logic          inflight, inflight_last, pop, last_rd;
  logic [1:0]    out_cnt;
  logic [2:0]    pend;
  assign S_AXIS_TREADY = ~FIFO_FULL;
  assign FIFO_WR_EN    = S_AXIS_TVALID & ~FIFO_FULL;
  assign FIFO_WR_DATA  = S_AXIS_TDATA;
  assign M_AXIS_TVALID = out_cnt != 2'd0;
  assign pop           = M_AXIS_TVALID & M_AXIS_TREADY;
  // words already owed to the buffer after this cycle's pop; below 2 keeps one read per cycle
  assign pend          = {1'b0, out_cnt} + {2'b0, inflight} - {2'b0, pop};
  assign last_rd       = reads == LW'(FRAME_LEN - 1);
  assign FIFO_RD_EN    = state == BURST && reads < LW'(FRAME_LEN) && level != '0 && pend < 3'd2 && !FIFO_EMPTY;
  assign FRAME_DONE    = pop & M_AXIS_TLAST;
  assign FILL_LEVEL    = level;
  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      state         <= IDLE;
      level         <= '0;
      reads         <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      FRAME_CNT     <= '0;
    end else begin
      level         <= level + LW'(FIFO_WR_EN) - LW'(FIFO_RD_EN);
      inflight      <= FIFO_RD_EN;
      inflight_last <= FIFO_RD_EN & last_rd;
      if (FRAME_DONE) FRAME_CNT <= FRAME_CNT + CNT_W'(1);
      if (state == IDLE && ENABLE && level >= LW'(FRAME_LEN)) begin
        reads <= '0;
        state <= BURST;
      end else if (state == BURST && FIFO_RD_EN) begin
        reads <= reads + LW'(1);
        if (last_rd) state <= DRAIN;
      end else if (state == DRAIN && FRAME_DONE) begin
        state <= IDLE;
      end
    end
  end
  lpc_out_skid #(.W(DATA_WIDTH)) u_skid (
    .clk       (ACLK),
    .rst_n     (ARESET_N),
    .push      (inflight),
    .push_data (FIFO_RD_DATA),
    .push_last (inflight_last),
    .pop       (pop),
    .data      (M_AXIS_TDATA),
    .last      (M_AXIS_TLAST),
    .cnt       (out_cnt)
  );
endmodule

// File: tb/tb_lpc_frame_scheduler.sv
// tb_lpc_frame_scheduler: FIFO model plus frame-level scoreboard around the scheduler
module tb_lpc_frame_scheduler;
  localparam int DW = 16, DEPTH = 8, FL = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic enable = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, wr_en, rd_en, f_empty, f_full, out_valid, out_last, frame_done;
  logic [DW-1:0] wr_data, f_rd, out_data;
  logic [3:0] fill;
  logic [15:0] frame_cnt;
  logic [DW-1:0] f_mem [DEPTH];
  logic [2:0] f_wp, f_rp;
  int f_count;
  always #5 clk = ~clk;
  assign f_full  = f_count == DEPTH;
  assign f_empty = f_count == 0;
  // reference synchronous FIFO with registered read data
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_wp <= '0; f_rp <= '0; f_count <= 0; f_rd <= '0;
    end else begin
      if (wr_en && f_count < DEPTH) begin f_mem[f_wp] <= wr_data; f_wp <= f_wp + 3'd1; end
      if (rd_en && f_count != 0) begin f_rd <= f_mem[f_rp]; f_rp <= f_rp + 3'd1; end
      f_count <= f_count + int'(wr_en && f_count < DEPTH) - int'(rd_en && f_count != 0);
    end
  end
  lpc_frame_scheduler #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FRAME_LEN(FL), .CNT_W(16)) dut (
    .ACLK(clk), .ARESET_N(rst_n), .ENABLE(enable),
    .S_AXIS_TVALID(in_valid), .S_AXIS_TREADY(in_ready), .S_AXIS_TDATA(in_data),
    .FIFO_WR_EN(wr_en), .FIFO_WR_DATA(wr_data), .FIFO_RD_EN(rd_en), .FIFO_RD_DATA(f_rd),
    .FIFO_EMPTY(f_empty), .FIFO_FULL(f_full),
    .M_AXIS_TVALID(out_valid), .M_AXIS_TREADY(out_ready), .M_AXIS_TDATA(out_data),
    .M_AXIS_TLAST(out_last), .FILL_LEVEL(fill), .FRAME_DONE(frame_done), .FRAME_CNT(frame_cnt));

  int checks = 0, fails = 0;
  logic [DW-1:0] in_q [$];
  int in_total = 0, out_n = 0, beats = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
  bit acc, hold_pend = 0, hold_last;
  logic [DW-1:0] hold_data;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    in_q.delete();
    in_total = 0; out_n = 0; beats = 0; hold_pend = 0;
  endtask

  // one clock: judge the cycle at the falling edge, then let it commit
  task automatic step();
    logic [DW-1:0] exp;
    @(negedge clk);
    acc = 0;
    if (rst_n) begin
      chk(in_ready == !f_full, "s_tready", 32'(in_ready), 32'(!f_full));
      chk(wr_en == (in_valid && !f_full), "fifo_wr_en", 32'(wr_en), 32'(in_valid && !f_full));
      chk(32'(fill) == 32'(f_count), "fill_level", 32'(fill), 32'(f_count));
      chk(32'(frame_cnt) == 32'(out_n / FL), "frame_cnt", 32'(frame_cnt), 32'(out_n / FL));
      if (rd_en) chk(!f_empty, "rd_while_empty", 32'(rd_en), 32'(0));
      if (hold_pend)
        chk(out_valid && out_data == hold_data && out_last == hold_last, "hold_stable",
            {15'd0, out_valid, out_data}, {15'd0, 1'b1, hold_data});
      if (out_valid && out_ready) begin
        if (in_q.size() == 0) chk(0, "spurious_beat", 32'(out_data), 32'(0));
        else begin
          exp = in_q.pop_front();
          chk(out_data == exp, "tdata", 32'(out_data), 32'(exp));
        end
        chk(out_last == (out_n % FL == FL - 1), "tlast", 32'(out_last), 32'(out_n % FL == FL - 1));
        chk(frame_done == (out_n % FL == FL - 1), "frame_done", 32'(frame_done), 32'(out_n % FL == FL - 1));
        chk(in_total >= (out_n / FL + 1) * FL, "partial_frame", 32'(in_total), 32'((out_n / FL + 1) * FL));
        if (beats == 0) first_cyc = cyc;
        last_cyc = cyc;
        out_n++; beats++;
      end else chk(!frame_done, "frame_done_idle", 32'(frame_done), 32'(0));
      hold_pend = out_valid && !out_ready;
      hold_data = out_data; hold_last = out_last;
      if (in_valid && !f_full) begin in_q.push_back(in_data); in_total++; acc = 1; end
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(!out_valid && !out_last && out_data == '0 && !frame_done && frame_cnt == '0 && !rd_en && in_ready && fill == '0,
        tag, {out_valid, out_last, frame_done, rd_en, in_ready, fill, out_data}, {4'b0000, 1'b1, 4'h0, 16'h0});
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 0; in_valid = 0; out_ready = 0;
    clear_model();
    #1 check_reset_outputs("reset_values");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {int n_wr; int en_cyc; int exp_beats; int exp_fill; int exp_cnt;} vec_t;
  vec_t vt [6];
  logic [DW-1:0] nd;

  initial begin
    int n_acc;
    vt[0] = '{4, 1000, 4, 0, 1};
    vt[1] = '{3, 1000, 0, 3, 1};
    vt[2] = '{1, 1000, 4, 0, 2};
    vt[3] = '{8, 0,    0, 8, 2};
    vt[4] = '{0, 1,    4, 4, 3};
    vt[5] = '{0, 1000, 4, 0, 4};
    do_reset();
    nd = 16'h0001;
    foreach (vt[v]) begin
      beats = 0;
      for (int c = 0; c < vt[v].n_wr + 30; c++) begin
        enable = c < vt[v].en_cyc; in_valid = c < vt[v].n_wr; in_data = nd; out_ready = 1;
        step();
        if (acc) nd++;
      end
      in_valid = 0;
      chk(beats == vt[v].exp_beats, $sformatf("vec%0d_beats", v), 32'(beats), 32'(vt[v].exp_beats));
      chk(32'(fill) == 32'(vt[v].exp_fill), $sformatf("vec%0d_fill", v), 32'(fill), 32'(vt[v].exp_fill));
      chk(32'(frame_cnt) == 32'(vt[v].exp_cnt), $sformatf("vec%0d_cnt", v), 32'(frame_cnt), 32'(vt[v].exp_cnt));
      if (beats == FL) chk(last_cyc - first_cyc == FL - 1, $sformatf("vec%0d_gapless", v), 32'(last_cyc - first_cyc), 32'(FL - 1));
    end
    // downstream stall: buffer fills to 2, FIFO to full, input then back-pressured
    enable = 1; out_ready = 0; n_acc = 0;
    for (int c = 0; c < 40 && n_acc < 10; c++) begin
      in_valid = 1; in_data = nd;
      step();
      if (acc) begin nd++; n_acc++; end
    end
    repeat (5) step();
    chk(n_acc == 10, "stall_accepted", 32'(n_acc), 32'(10));
    chk(fill == 4'd8 && !in_ready && out_valid, "stall_full", {fill, in_ready, out_valid}, {4'd8, 1'b0, 1'b1});
    in_valid = 0; out_ready = 1; beats = 0;
    repeat (30) step();
    chk(beats == 8 && fill == 4'd2 && frame_cnt == 16'd6, "stall_release", {beats[15:0], 12'(fill), frame_cnt[3:0]}, {16'd8, 12'd2, 4'd6});
    beats = 0;
    for (int c = 0; c < 32; c++) begin
      in_valid = c < 2; in_data = nd;
      step();
      if (acc) nd++;
    end
    in_valid = 0;
    chk(beats == 4 && fill == 4'd0, "stall_tail_frame", {beats[15:0], 12'(fill)}, {16'd4, 12'd0});
    // reset in the middle of a frame
    do_reset();
    enable = 1; out_ready = 1; beats = 0;
    for (int c = 0; c < 40 && beats < 2; c++) begin
      in_valid = c < 4; in_data = nd;
      step();
      if (acc) nd++;
    end
    chk(beats == 2, "midframe_reach", 32'(beats), 32'(2));
    rst_n = 1'b0; in_valid = 0;
    #1 check_reset_outputs("midframe_reset");
    clear_model();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 34; c++) begin
      in_valid = c < 4; in_data = nd;
      step();
      if (acc) nd++;
    end
    in_valid = 0;
    chk(beats == 4 && frame_cnt == 16'd1 && fill == 4'd0, "fresh_frame", {beats[15:0], frame_cnt}, {16'd4, 16'd1});
    // randomised traffic
    do_reset();
    enable = 1; n_acc = 0; in_data = DW'($urandom);
    for (int c = 0; c < 30000 && beats < 1000; c++) begin
      in_valid = n_acc < 1000 && $urandom_range(3) != 0;
      out_ready = $urandom_range(2) != 0;
      step();
      if (acc) begin n_acc++; in_data = DW'($urandom); end
    end
    in_valid = 0;
    chk(beats == 1000, "rand_beats", 32'(beats), 32'(1000));
    chk(frame_cnt == 16'd250, "rand_frames", 32'(frame_cnt), 32'(250));
    chk(fill == 4'd0 && in_q.size() == 0, "rand_empty", 32'(fill), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
